core_ctrl: RTL and testbench
============================

CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 SHALL have parameter WD_LIMIT, default 8'd200: watchdog expiry count in cycles.
REQ-002 SHALL have ports: mc_clk  in  1  clock; rising edge active.
REQ-003 SHALL have ports: mc_reset  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have ports: cc_start  in  1  start a job; sampled in IDLE only.
REQ-005 SHALL have ports: cc_length  in  6  last word index of the job; job has cc_length+1 words.
REQ-006 SHALL have ports: cc_abort  in  1  abort the current job.
REQ-007 SHALL have ports: mc_done  in  1  memory-controller step-complete flag.
REQ-008 SHALL have ports: mc_data_done  in  1  memory-controller end-of-memory flag.
REQ-009 SHALL have ports: pu_done  in  1  processing units finished the current operand pair.
REQ-010 SHALL have ports: mc_data_contition  out  3  command to the memory controller.
REQ-011 SHALL have ports: mc_data_length  out  6  latched job length to the memory controller.
REQ-012 SHALL have ports: pu_start  out  1  one-cycle pulse; operand pair valid for processing.
REQ-013 SHALL have ports: cc_busy  out  1  high in every state except IDLE.
REQ-014 SHALL have ports: cc_finished  out  1  one-cycle pulse at normal job end.
REQ-015 SHALL have ports: cc_error  out  1  sticky watchdog-expiry flag; cleared by the next accepted cc_start.

Function
REQ-016 SHALL register all outputs; the command encodings SHALL be IDLE=000, STORE=100, NEXT=010, PROC=001.
REQ-017 SHALL implement the states IDLE, STORE, FETCH, PROC and DONE.
REQ-018 IDLE: on cc_start=1, SHALL latch mc_data_length=min(cc_length,31), clear the pass counter and cc_error, drive 100, and enter STORE on the next edge.
REQ-019 STORE: SHALL hold 100; on mc_done=1, SHALL keep 100 and enter FETCH.
REQ-020 FETCH: SHALL hold 100; on mc_done=1, SHALL drive 001, pulse pu_start for exactly one cycle, and enter PROC.
REQ-021 PROC: SHALL hold 001 until pu_done=1.
REQ-022 PROC with pu_done=1: if pass counter==mc_data_length or mc_data_done=1, SHALL enter DONE; otherwise SHALL increment the 6-bit pass counter, drive 010 for exactly one cycle, then drive 100 and enter FETCH.
REQ-023 DONE: SHALL drive 000, pulse cc_finished for one cycle, and return to IDLE.
REQ-024 cc_abort=1 in any non-IDLE state SHALL drive 000 and enter IDLE on the next edge, without asserting cc_finished; abort SHALL take priority over every other transition in the same cycle.
REQ-025 The watchdog SHALL count cycles spent waiting in STORE, FETCH and PROC, and SHALL restart on every state change.
REQ-026 On watchdog count==WD_LIMIT, SHALL set cc_error, drive 000 and enter IDLE; cc_abort in the same cycle SHALL still take priority, and cc_error SHALL be set anyway.
REQ-027 cc_start outside IDLE SHALL be ignored.
REQ-028 cc_length changes after latching SHALL have no effect until the next job.
REQ-029 The pass counter SHALL never wrap, because it is bounded by mc_data_length≤31.
REQ-030 pu_done outside PROC and mc_done in IDLE or PROC SHALL be ignored.

Reset
REQ-031 While mc_reset=1, state=IDLE, mc_data_contition=000, mc_data_length=0, pu_start=0, cc_busy=0, cc_finished=0, cc_error=0, pass counter=0 and watchdog=0.
REQ-032 Reset asserted mid-job SHALL abandon the job immediately, with no pulse on any output.
REQ-033 The first command after reset release SHALL be issued no earlier than the first rising edge with mc_reset=0.

Structure
REQ-034 The command encodings (000/100/010/001), the state encodings and the WD_LIMIT default SHALL live in the shared package mem_ctrl_pkg, which is also used by the memory controller.
REQ-035 The watchdog SHALL be a separate sub-module cc_watchdog with ports clk, reset, clear, enable, limit and expired.
REQ-036 The core_ctrl FSM and the pass counter SHALL remain in core_ctrl.

Verification
REQ-037 Normal job: cc_length=2, mc_done after 3 cycles in each state, pu_done 2 cycles after each pu_start -> exactly 3 pu_start pulses, two one-cycle 010 commands, cc_finished once, mc_data_contition returns to 000.
REQ-038 Length saturation: cc_length=6'd40 -> mc_data_length=31 and 32 pu_start pulses before cc_finished.
REQ-039 Early end: cc_length=10, mc_data_done=1 during the 4th PROC with pu_done -> DONE after 4 passes, no further 010.
REQ-040 Abort: cc_abort in FETCH on the same cycle as mc_done -> no pu_start, 000 next cycle, cc_busy=0, cc_finished=0.
REQ-041 Watchdog: WD_LIMIT=8'd10, mc_done held low in STORE -> cc_error=1 after 10 waiting cycles, state IDLE; the next cc_start clears cc_error.
REQ-042 Async reset mid-PROC -> all outputs return to their reset values without a clock edge; a job started after reset completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-controller / core-controller pair.
// Holds the memory command encodings, the core_ctrl state encodings,
// the default watchdog limit and the request payload seen by the
// memory controller.
package mem_ctrl_pkg;

    localparam int unsigned CMD_W = 3;
    localparam int unsigned LEN_W = 6;
    localparam int unsigned WD_W  = 8;
    localparam int unsigned ST_W  = 3;

    // Longest job the memory controller accepts (last word index).
    localparam logic [LEN_W-1:0] LEN_MAX          = LEN_W'(31);
    localparam logic [WD_W-1:0]  WD_LIMIT_DEFAULT = WD_W'(200);

    // Commands towards the memory controller.
    typedef enum logic [CMD_W-1:0] {
        CMD_IDLE  = 3'b000,
        CMD_STORE = 3'b100,
        CMD_NEXT  = 3'b010,
        CMD_PROC  = 3'b001
    } mc_cmd_e;

    // core_ctrl FSM states.
    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_STORE = 3'd1,
        ST_FETCH = 3'd2,
        ST_PROC  = 3'd3,
        ST_DONE  = 3'd4
    } cc_state_e;

    // Command plus latched job length, as presented to the memory controller.
    typedef struct packed {
        mc_cmd_e          cmd;
        logic [LEN_W-1:0] len;
    } mc_req_t;

    localparam mc_req_t MC_REQ_RESET = '{cmd: CMD_IDLE, len: '0};

    // Clamp a requested last-word index to the supported range.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

endpackage : mem_ctrl_pkg

// File: rtl/cc_watchdog.sv
// Wait-cycle watchdog for core_ctrl.
// Counts cycles while enabled; the count restarts whenever clear is high
// and stops at limit. expired flags an enabled count sitting at limit.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-high reset
//   clear    in   restart the count (takes priority over enable)
//   enable   in   count this cycle
//   limit    in   expiry count
//   expired  out  enable && count == limit (combinational)
module cc_watchdog
    import mem_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    input  logic [WD_W-1:0] limit,
    output logic            expired
);

    logic [WD_W-1:0] cnt_q;
    logic [WD_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and park at limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != limit)) begin
            cnt_d = cnt_q + WD_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is only meaningful while the owner is actually waiting.
    assign expired = enable && (cnt_q == limit);

endmodule : cc_watchdog

// File: rtl/core_ctrl.sv
// Core controller: sequences a job of cc_length+1 operand passes through
// the memory controller (store, fetch, process) and the processing units,
// with abort and a wait-cycle watchdog.
//
// Ports:
//   mc_clk             in   clock, rising edge
//   mc_reset           in   asynchronous, active-high reset
//   cc_start           in   start a job (accepted in IDLE only)
//   cc_length[5:0]     in   last word index of the job
//   cc_abort           in   abort the running job
//   mc_done            in   memory-controller step complete
//   mc_data_done       in   memory-controller end of memory
//   pu_done            in   processing units finished the operand pair
//   mc_data_contition  out  command to the memory controller
//   mc_data_length     out  latched (clamped) job length
//   pu_start           out  one-cycle pulse, operand pair valid
//   cc_busy            out  high in every state except IDLE
//   cc_finished        out  one-cycle pulse on normal job end
//   cc_error           out  sticky watchdog-expiry flag
module core_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [WD_W-1:0] WD_LIMIT = WD_LIMIT_DEFAULT
) (
    input  logic              mc_clk,
    input  logic              mc_reset,
    input  logic              cc_start,
    input  logic [LEN_W-1:0]  cc_length,
    input  logic              cc_abort,
    input  logic              mc_done,
    input  logic              mc_data_done,
    input  logic              pu_done,
    output logic [CMD_W-1:0]  mc_data_contition,
    output logic [LEN_W-1:0]  mc_data_length,
    output logic              pu_start,
    output logic              cc_busy,
    output logic              cc_finished,
    output logic              cc_error
);

    cc_state_e        state_q;
    cc_state_e        state_d;
    mc_req_t          req_q;
    mc_req_t          req_d;
    logic [LEN_W-1:0] pass_q;
    logic [LEN_W-1:0] pass_d;
    logic             pu_start_q;
    logic             pu_start_d;
    logic             busy_q;
    logic             busy_d;
    logic             fin_q;
    logic             fin_d;
    logic             err_q;
    logic             err_d;

    logic             abort_c;
    logic             wd_en_c;
    logic             wd_clr_c;
    logic             wd_exp_c;
    logic             last_pass_c;

    // Abort is only honoured while a job is running.
    assign abort_c     = cc_abort && (state_q != ST_IDLE);
    assign wd_en_c     = (state_q == ST_STORE) || (state_q == ST_FETCH) || (state_q == ST_PROC);
    assign wd_clr_c    = (state_d != state_q);
    assign last_pass_c = (pass_q == req_q.len) || mc_data_done;

    cc_watchdog u_watchdog (
        .clk     (mc_clk),
        .reset   (mc_reset),
        .clear   (wd_clr_c),
        .enable  (wd_en_c),
        .limit   (WD_LIMIT),
        .expired (wd_exp_c)
    );

    // State register.
    always_ff @(posedge mc_clk or posedge mc_reset) begin
        if (mc_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort and watchdog expiry override every transition.
    always_comb begin
        state_d = state_q;
        if (abort_c || wd_exp_c) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (cc_start) state_d = ST_STORE;
                ST_STORE: if (mc_done)  state_d = ST_FETCH;
                ST_FETCH: if (mc_done)  state_d = ST_PROC;
                ST_PROC:  if (pu_done)  state_d = last_pass_c ? ST_DONE : ST_FETCH;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output and datapath next values, registered below.
    always_comb begin
        req_d      = req_q;
        pass_d     = pass_q;
        pu_start_d = 1'b0;
        fin_d      = 1'b0;
        err_d      = err_q;

        // Expiry flags an error even when an abort steals the transition.
        if (wd_exp_c) begin
            err_d = 1'b1;
        end

        if (abort_c || wd_exp_c) begin
            req_d.cmd = CMD_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_d.cmd = CMD_IDLE;
                    if (cc_start) begin
                        req_d.cmd = CMD_STORE;
                        req_d.len = sat_len(cc_length);
                        pass_d    = '0;
                        err_d     = 1'b0;
                    end
                end
                ST_STORE: begin
                    req_d.cmd = CMD_STORE;
                end
                ST_FETCH: begin
                    // Also turns the one-cycle NEXT command back into STORE.
                    req_d.cmd = CMD_STORE;
                    if (mc_done) begin
                        req_d.cmd  = CMD_PROC;
                        pu_start_d = 1'b1;
                    end
                end
                ST_PROC: begin
                    req_d.cmd = CMD_PROC;
                    if (pu_done) begin
                        if (last_pass_c) begin
                            req_d.cmd = CMD_IDLE;
                            fin_d     = 1'b1;
                        end else begin
                            // len is clamped to 31, so this never wraps.
                            req_d.cmd = CMD_NEXT;
                            pass_d    = pass_q + LEN_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    req_d.cmd = CMD_IDLE;
                end
                default: begin
                    req_d.cmd = CMD_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Output and datapath registers.
    always_ff @(posedge mc_clk or posedge mc_reset) begin
        if (mc_reset) begin
            req_q      <= MC_REQ_RESET;
            pass_q     <= '0;
            pu_start_q <= 1'b0;
            busy_q     <= 1'b0;
            fin_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            req_q      <= req_d;
            pass_q     <= pass_d;
            pu_start_q <= pu_start_d;
            busy_q     <= busy_d;
            fin_q      <= fin_d;
            err_q      <= err_d;
        end
    end

    assign mc_data_contition = req_q.cmd;
    assign mc_data_length    = req_q.len;
    assign pu_start          = pu_start_q;
    assign cc_busy           = busy_q;
    assign cc_finished       = fin_q;
    assign cc_error          = err_q;

endmodule : core_ctrl

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl with a short watchdog limit.
module tb_core_ctrl;

    logic       mc_clk = 1'b0;
    logic       mc_reset;
    logic       cc_start;
    logic [5:0] cc_length;
    logic       cc_abort;
    logic       mc_done;
    logic       mc_data_done;
    logic       pu_done;
    logic [2:0] mc_data_contition;
    logic [5:0] mc_data_length;
    logic       pu_start;
    logic       cc_busy;
    logic       cc_finished;
    logic       cc_error;

    int n_vec = 0;
    int n_mis = 0;
    int n_pu, n_next, n_fin, max_run;

    core_ctrl #(.WD_LIMIT(8'd10)) dut (
        .mc_clk            (mc_clk),
        .mc_reset          (mc_reset),
        .cc_start          (cc_start),
        .cc_length         (cc_length),
        .cc_abort          (cc_abort),
        .mc_done           (mc_done),
        .mc_data_done      (mc_data_done),
        .pu_done           (pu_done),
        .mc_data_contition (mc_data_contition),
        .mc_data_length    (mc_data_length),
        .pu_start          (pu_start),
        .cc_busy           (cc_busy),
        .cc_finished       (cc_finished),
        .cc_error          (cc_error)
    );

    always #5 mc_clk = ~mc_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept a job; returns at the first negedge in STORE.
    task automatic start_job(input logic [5:0] len, input logic [5:0] exp_len);
        @(negedge mc_clk);
        cc_start  = 1'b1;
        cc_length = len;
        @(negedge mc_clk);
        cc_start  = 1'b0;
        cc_length = ~len;
        check("start_cmd", mc_data_contition, 3'b100);
        check("start_len", mc_data_length, exp_len);
        check("start_busy", cc_busy, 1'b1);
        check("start_err", cc_error, 1'b0);
    endtask

    // Responder: mc_done on the 3rd consecutive STORE-command cycle,
    // pu_done 2 cycles after pu_start, mc_data_done on pu_done number ddone_pass.
    task automatic run_job(input int ddone_pass, input int max_cyc,
                           output int o_pu, output int o_next, output int o_fin, output int o_run);
        int c100 = 0;
        int pc = 0;
        int n_pud = 0;
        int run = 0;
        int cyc = 0;
        bit seen = 1'b0;
        o_pu = 0; o_next = 0; o_fin = 0; o_run = 0;
        while (!seen && cyc < max_cyc) begin
            mc_done = 1'b0; pu_done = 1'b0; mc_data_done = 1'b0;
            if (pu_start) begin
                o_pu++;
                pc = 2;
            end else if (pc > 0) begin
                pc--;
                if (pc == 0) begin
                    pu_done = 1'b1;
                    n_pud++;
                    if (n_pud == ddone_pass) mc_data_done = 1'b1;
                end
            end
            if (mc_data_contition == 3'b100) begin
                c100++;
                if (c100 == 3) begin
                    mc_done = 1'b1;
                    c100 = 0;
                end
            end else begin
                c100 = 0;
            end
            if (mc_data_contition == 3'b010) begin
                run++;
                if (run == 1) o_next++;
                if (run > o_run) o_run = run;
            end else begin
                run = 0;
            end
            if (cc_finished) begin
                o_fin++;
                seen = 1'b1;
            end
            @(negedge mc_clk);
            cyc++;
        end
        mc_done = 1'b0; pu_done = 1'b0; mc_data_done = 1'b0;
        check("job_timeout", seen, 1'b1);
        check("end_fin_pulse", cc_finished, 1'b0);
        check("end_busy", cc_busy, 1'b0);
        check("end_cmd", mc_data_contition, 3'b000);
    endtask

    initial begin
        mc_reset = 1'b1; cc_start = 1'b0; cc_length = '0; cc_abort = 1'b0;
        mc_done = 1'b0; mc_data_done = 1'b0; pu_done = 1'b0;

        // Reset values without any clock edge.
        #1;
        check("rst_cmd", mc_data_contition, 3'b000);
        check("rst_len", mc_data_length, 6'd0);
        check("rst_pu", pu_start, 1'b0);
        check("rst_busy", cc_busy, 1'b0);
        check("rst_fin", cc_finished, 1'b0);
        check("rst_err", cc_error, 1'b0);
        @(negedge mc_clk);
        mc_reset = 1'b0;

        // Stray handshakes and abort in IDLE do nothing.
        @(negedge mc_clk);
        mc_done = 1'b1; pu_done = 1'b1; cc_abort = 1'b1;
        @(negedge mc_clk);
        mc_done = 1'b0; pu_done = 1'b0; cc_abort = 1'b0;
        check("idle_busy", cc_busy, 1'b0);
        check("idle_cmd", mc_data_contition, 3'b000);
        check("idle_pu", pu_start, 1'b0);

        // Normal job, 3 passes.
        start_job(6'd2, 6'd2);
        run_job(0, 200, n_pu, n_next, n_fin, max_run);
        check("norm_pu", n_pu, 3);
        check("norm_next", n_next, 2);
        check("norm_next_len", max_run, 1);
        check("norm_fin", n_fin, 1);
        check("norm_len_held", mc_data_length, 6'd2);

        // Length saturates at 31 -> 32 passes.
        start_job(6'd40, 6'd31);
        run_job(0, 1000, n_pu, n_next, n_fin, max_run);
        check("sat_pu", n_pu, 32);
        check("sat_next", n_next, 31);
        check("sat_fin", n_fin, 1);

        // End of memory on the 4th pass.
        start_job(6'd10, 6'd10);
        run_job(4, 400, n_pu, n_next, n_fin, max_run);
        check("early_pu", n_pu, 4);
        check("early_next", n_next, 3);
        check("early_fin", n_fin, 1);

        // Restart ignored while busy, then abort in FETCH alongside mc_done.
        start_job(6'd2, 6'd2);
        cc_start = 1'b1; cc_length = 6'd5; mc_done = 1'b1;
        @(negedge mc_clk);
        cc_start = 1'b0;
        check("busy_start_len", mc_data_length, 6'd2);
        check("fetch_cmd", mc_data_contition, 3'b100);
        mc_done = 1'b1; cc_abort = 1'b1;
        @(negedge mc_clk);
        mc_done = 1'b0; cc_abort = 1'b0;
        check("abort_pu", pu_start, 1'b0);
        check("abort_cmd", mc_data_contition, 3'b000);
        check("abort_busy", cc_busy, 1'b0);
        check("abort_fin", cc_finished, 1'b0);
        @(negedge mc_clk);
        check("abort_fin2", cc_finished, 1'b0);
        check("abort_err", cc_error, 1'b0);

        // Watchdog: STORE never completes; count reaches 10 then trips.
        start_job(6'd2, 6'd2);
        repeat (10) @(negedge mc_clk);
        check("wd_pre_err", cc_error, 1'b0);
        check("wd_pre_busy", cc_busy, 1'b1);
        @(negedge mc_clk);
        check("wd_err", cc_error, 1'b1);
        check("wd_busy", cc_busy, 1'b0);
        check("wd_cmd", mc_data_contition, 3'b000);
        check("wd_fin", cc_finished, 1'b0);
        repeat (3) @(negedge mc_clk);
        check("wd_sticky", cc_error, 1'b1);

        // Expiry coinciding with abort still flags the error.
        start_job(6'd2, 6'd2);
        repeat (10) @(negedge mc_clk);
        cc_abort = 1'b1;
        @(negedge mc_clk);
        cc_abort = 1'b0;
        check("wdab_err", cc_error, 1'b1);
        check("wdab_busy", cc_busy, 1'b0);
        start_job(6'd1, 6'd1);
        run_job(0, 200, n_pu, n_next, n_fin, max_run);
        check("wd_after_pu", n_pu, 2);
        check("wd_after_fin", n_fin, 1);
        check("wd_after_err", cc_error, 1'b0);

        // Async reset in PROC, then a clean job.
        start_job(6'd3, 6'd3);
        mc_done = 1'b1;
        @(negedge mc_clk);
        mc_done = 1'b1;
        @(negedge mc_clk);
        mc_done = 1'b0;
        check("proc_pu", pu_start, 1'b1);
        check("proc_cmd", mc_data_contition, 3'b001);
        #2;
        mc_reset = 1'b1;
        #1;
        check("arst_cmd", mc_data_contition, 3'b000);
        check("arst_len", mc_data_length, 6'd0);
        check("arst_pu", pu_start, 1'b0);
        check("arst_busy", cc_busy, 1'b0);
        check("arst_fin", cc_finished, 1'b0);
        check("arst_err", cc_error, 1'b0);
        @(negedge mc_clk);
        mc_reset = 1'b0;
        start_job(6'd3, 6'd3);
        run_job(0, 300, n_pu, n_next, n_fin, max_run);
        check("post_rst_pu", n_pu, 4);
        check("post_rst_next", n_next, 3);
        check("post_rst_fin", n_fin, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule : tb_core_ctrl
